// File: rtl/instr_history_buffer_pkg.sv
// rtl/instr_history_buffer_pkg.sv - shared pipeline constants for the instruction history buffer
package instr_history_buffer_pkg;

    // Default stored word width: packed instruction plus control bits.
    localparam int INSTR_BUF_W = 49;

    // Default number of history entries.
    localparam int HIST_DEPTH = 4;

    // Field layout of the packed instruction word, for consumers of read_data.
    localparam int INSTR_LSB   = 0;
    localparam int INSTR_W     = 32;
    localparam int PC_LO_LSB   = 32;
    localparam int PC_LO_W     = 16;
    localparam int CTRL_RVC_BIT = 48;

endpackage

// File: rtl/instr_history_buffer.sv
// rtl/instr_history_buffer.sv - circular history of the last DEPTH instruction words
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   write_enable, write_data  push a word as the newest entry
//   pop                       discard the newest entry
//   flush                     invalidate all entries
//   read_age                  age of entry to read (0 = newest)
//   read_data, read_valid     registered read result, one cycle after read_age
//   count, full, empty        number of valid entries and its flags
module instr_history_buffer
    import instr_history_buffer_pkg::*;
#(
    parameter int Width = INSTR_BUF_W,
    parameter int DEPTH = HIST_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_enable,
    input  logic [Width-1:0] write_data,
    input  logic             pop,
    input  logic             flush,
    input  logic [AW-1:0]    read_age,
    output logic [Width-1:0] read_data,
    output logic             read_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [Width-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW:0]      count_q;

    logic             is_empty;
    logic             do_push;
    logic             do_replace;
    logic             do_pop;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    newest_slot;
    logic [AW-1:0]    rd_slot;
    logic             rd_hit;

    assign is_empty = (count_q == '0);

    // Push+pop on a non-empty buffer rewrites the newest entry in place;
    // on an empty buffer there is nothing to replace, so it is a plain push.
    assign do_push    = write_enable && (!pop || is_empty);
    assign do_replace = write_enable && pop && !is_empty;
    assign do_pop     = pop && !write_enable && !is_empty;

    assign newest_slot = wp - AW'(1);
    assign mem_we      = !rst && !flush && (do_push || do_replace);
    assign mem_waddr   = do_replace ? newest_slot : wp;

    // DEPTH is a power of two, so AW-bit wrap is exactly mod DEPTH.
    assign rd_slot = newest_slot - read_age;
    assign rd_hit  = ({1'b0, read_age} < count_q);

    // Storage carries no reset; read_valid gating keeps stale words hidden.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            count_q    <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            // Read uses pre-update state: a same-cycle push is not visible yet.
            read_valid <= rd_hit;
            read_data  <= rd_hit ? mem[rd_slot] : '0;

            if (flush) begin
                wp      <= '0;
                count_q <= '0;
            end else if (do_push) begin
                wp <= wp + AW'(1);
                if (count_q != DEPTH_CNT) begin
                    count_q <= count_q + (AW+1)'(1);
                end
            end else if (do_pop) begin
                wp      <= newest_slot;
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign count = count_q;
    assign full  = (count_q == DEPTH_CNT);
    assign empty = is_empty;

endmodule

// File: tb/tb_instr_history_buffer.sv
// tb/tb_instr_history_buffer.sv - table-driven self-checking bench for instr_history_buffer
module tb_instr_history_buffer;

    localparam int W  = 49;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          write_enable;
    logic [W-1:0]  write_data;
    logic          pop;
    logic          flush;
    logic [AW-1:0] read_age;
    logic [W-1:0]  read_data;
    logic          read_valid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    instr_history_buffer #(.Width(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .write_data   (write_data),
        .pop          (pop),
        .flush        (flush),
        .read_age     (read_age),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          we;
        logic          pop;
        logic [W-1:0]  wd;
        logic [AW-1:0] age;
        logic          ev;
        logic [W-1:0]  ed;
        int            ec;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic f, input logic we, input logic p,
                       input logic [W-1:0] wd, input logic [AW-1:0] age,
                       input logic ev, input logic [W-1:0] ed, input int ec);
        vec_t v;
        v.rst = r; v.flush = f; v.we = we; v.pop = p; v.wd = wd; v.age = age;
        v.ev = ev; v.ed = ed; v.ec = ec;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive at negedge, let the posedge act, sample 1 time unit later.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; flush = v.flush; write_enable = v.we; pop = v.pop;
        write_data = v.wd; read_age = v.age;
        @(posedge clk);
        #1;
        chk("read_valid", idx, 64'(read_valid), 64'(v.ev));
        chk("read_data",  idx, 64'(read_data),  64'(v.ed));
        chk("count",      idx, 64'(count),      64'(v.ec));
        chk("full",       idx, 64'(full),       64'(v.ec == D));
        chk("empty",      idx, 64'(empty),      64'(v.ec == 0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; write_enable = 1'b0; pop = 1'b0;
        write_data = '0; read_age = '0;

        //   rst f  we p  wd       age ev ed       count
        add(1, 0, 0, 0, 49'h0,  0, 0, 49'h0,  0);   // reset
        add(0, 0, 0, 0, 49'h0,  0, 0, 49'h0,  0);
        add(0, 0, 1, 0, 49'h1,  0, 0, 49'h0,  1);   // read sees pre-push history
        add(0, 0, 1, 0, 49'h2,  0, 1, 49'h1,  2);
        add(0, 0, 1, 0, 49'h3,  0, 1, 49'h2,  3);
        add(0, 0, 0, 0, 49'h0,  0, 1, 49'h3,  3);
        add(0, 0, 0, 0, 49'h0,  1, 1, 49'h2,  3);
        add(0, 0, 0, 0, 49'h0,  2, 1, 49'h1,  3);
        add(0, 0, 0, 0, 49'h0,  3, 0, 49'h0,  3);   // age beyond count
        add(0, 0, 0, 1, 49'h0,  0, 1, 49'h3,  2);   // pop
        add(0, 0, 0, 0, 49'h0,  0, 1, 49'h2,  2);
        add(0, 0, 1, 1, 49'h7,  1, 1, 49'h1,  2);   // push+pop replaces newest
        add(0, 0, 0, 0, 49'h0,  0, 1, 49'h7,  2);
        add(0, 0, 0, 0, 49'h0,  1, 1, 49'h1,  2);
        add(0, 1, 1, 1, 49'h55, 0, 1, 49'h7,  0);   // flush wins over we/pop
        add(0, 0, 0, 0, 49'h0,  0, 0, 49'h0,  0);
        add(0, 0, 0, 1, 49'h0,  0, 0, 49'h0,  0);   // pop when empty
        add(0, 0, 1, 0, 49'h9,  0, 0, 49'h0,  1);
        add(0, 0, 0, 0, 49'h0,  0, 1, 49'h9,  1);
        add(0, 1, 0, 0, 49'h0,  0, 1, 49'h9,  0);
        add(0, 0, 1, 0, 49'hA,  0, 0, 49'h0,  1);   // six pushes, saturate + wrap
        add(0, 0, 1, 0, 49'hB,  0, 1, 49'hA,  2);
        add(0, 0, 1, 0, 49'hC,  0, 1, 49'hB,  3);
        add(0, 0, 1, 0, 49'hD,  0, 1, 49'hC,  4);
        add(0, 0, 1, 0, 49'hE,  0, 1, 49'hD,  4);
        add(0, 0, 1, 0, 49'hF,  0, 1, 49'hE,  4);
        add(0, 0, 0, 0, 49'h0,  0, 1, 49'hF,  4);
        add(0, 0, 0, 0, 49'h0,  3, 1, 49'hC,  4);
        add(0, 0, 0, 0, 49'h0,  1, 1, 49'hE,  4);
        add(0, 0, 0, 0, 49'h0,  2, 1, 49'hD,  4);
        add(1, 0, 1, 0, 49'h77, 0, 0, 49'h0,  0);   // reset while full and pushing
        add(0, 0, 0, 0, 49'h0,  0, 0, 49'h0,  0);
        add(0, 0, 1, 1, 49'h42, 0, 0, 49'h0,  1);   // push+pop on empty = push
        add(0, 0, 0, 0, 49'h0,  0, 1, 49'h42, 1);
        add(0, 0, 0, 1, 49'h0,  0, 1, 49'h42, 0);
        add(0, 0, 0, 0, 49'h0,  0, 0, 49'h0,  0);   // popped word stays hidden

        foreach (vq[i]) run_vec(vq[i], i);

        // Hand sequence: fill to full, flush, push one; older slots still
        // hold stale words but must not be exposed at ages 1..3.
        begin
            vec_t v;
            for (int k = 0; k < D; k++) begin
                v = '{rst:0, flush:0, we:1, pop:0, wd:49'h100 + 49'(k), age:0,
                      ev:(k != 0), ed:(k != 0) ? 49'h100 + 49'(k - 1) : 49'h0, ec:k + 1};
                run_vec(v, 100 + k);
            end
            v = '{rst:0, flush:1, we:0, pop:0, wd:49'h0, age:3, ev:1, ed:49'h100, ec:0};
            run_vec(v, 110);
            v = '{rst:0, flush:0, we:1, pop:0, wd:49'h1_2345_6789_ABCD, age:0, ev:0, ed:49'h0, ec:1};
            run_vec(v, 111);
            for (int a = 1; a < D; a++) begin
                v = '{rst:0, flush:0, we:0, pop:0, wd:49'h0, age:AW'(a), ev:0, ed:49'h0, ec:1};
                run_vec(v, 112 + a);
            end
            v = '{rst:0, flush:0, we:0, pop:0, wd:49'h0, age:0, ev:1, ed:49'h1_2345_6789_ABCD, ec:1};
            run_vec(v, 120);
            // Pop back through the pointer wrap (wp 1 -> 0), then push again.
            v = '{rst:0, flush:0, we:0, pop:1, wd:49'h0, age:0, ev:1, ed:49'h1_2345_6789_ABCD, ec:0};
            run_vec(v, 121);
            v = '{rst:0, flush:0, we:1, pop:0, wd:49'h66, age:0, ev:0, ed:49'h0, ec:1};
            run_vec(v, 122);
            v = '{rst:0, flush:0, we:0, pop:0, wd:49'h0, age:0, ev:1, ed:49'h66, ec:1};
            run_vec(v, 123);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
